// File: rtl/ecall_input_responder_pkg.sv
// Shared constants for the ecall input responder:
// syscall codes, data width and FSM state encoding.
package ecall_input_responder_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] PRINT_INT  = 32'd1;
  localparam logic [DATA_W-1:0] PRINT_STR  = 32'd4;
  localparam logic [DATA_W-1:0] READ_INT   = 32'd5;
  localparam logic [DATA_W-1:0] PRINT_CHAR = 32'd11;
  localparam logic [DATA_W-1:0] READ_UINT  = 32'd12;

  typedef logic [2:0] state_t;

  localparam state_t IDLE       = 3'd0;
  localparam state_t ARM        = 3'd1;
  localparam state_t WAIT_PRESS = 3'd2;
  localparam state_t DONE       = 3'd3;
  localparam state_t DRAIN      = 3'd4;

endpackage

// File: rtl/ecall_input_responder_io_debouncer.sv
// Button conditioner: 2-flop synchroniser, stability
// counter and one-cycle rising-edge press pulse.
module io_debouncer #(
  parameter int unsigned CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  logic s1;
  logic s2;
  logic lvl_q;

  // bring the asynchronous button into the clk domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  generate
    if (CYCLES == 0) begin : g_pass
      assign level = s2;
    end else begin : g_cnt
      localparam int CW = $clog2(CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

      logic [CW-1:0] cnt;
      logic          db;

      // flip the level only after a full run of disagreement
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt <= '0;
          db  <= 1'b0;
        end else if (s2 == db) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          cnt <= '0;
          db  <= s2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      assign level = db;
    end
  endgenerate

  // remember last level to find the rising edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lvl_q <= 1'b0;
    else      lvl_q <= level;
  end

  assign press = level & ~lvl_q;

endmodule

// File: rtl/ecall_input_responder.sv
// Input-side ecall responder: waits for a fresh button
// press and returns the switch bank as the a0 value.
import ecall_input_responder_pkg::*;

module ecall_input_responder #(
  parameter int unsigned       DEBOUNCE_CYCLES = 1_000_000,
  parameter int                SW_W            = 8,
  parameter logic [DATA_W-1:0] READ_INT_CODE   = READ_INT,
  parameter logic [DATA_W-1:0] READ_UINT_CODE  = READ_UINT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Ecall,
  input  logic [DATA_W-1:0] a7,
  input  logic [SW_W-1:0]   switches,
  input  logic              button,
  output logic              claim,
  output logic              busy,
  output logic              EcallDone,
  output logic              EcallWrite,
  output logic [DATA_W-1:0] EcallResult
);

  state_t state;
  logic   is_int;
  logic   btn_level;
  logic   btn_press;

  io_debouncer #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk  (clk),
    .rst  (rst),
    .raw  (button),
    .level(btn_level),
    .press(btn_press)
  );

  assign claim = Ecall &&
    (a7 == READ_INT_CODE || a7 == READ_UINT_CODE);

  assign busy       = (state != IDLE);
  assign EcallDone  = (state == DONE);
  assign EcallWrite = (state == DONE);

  // request sequencing, code latch and result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      is_int      <= 1'b0;
      EcallResult <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (claim) begin
            state  <= ARM;
            is_int <= (a7 == READ_INT_CODE);
          end
        end
        ARM: begin
          if (!Ecall)          state <= IDLE;
          else if (!btn_level) state <= WAIT_PRESS;
        end
        WAIT_PRESS: begin
          if (!Ecall) begin
            state <= IDLE;
          end else if (btn_press) begin
            state <= DONE;
            if (is_int)
              EcallResult <= {{(DATA_W-SW_W){switches[SW_W-1]}},
                              switches};
            else
              EcallResult <= {{(DATA_W-SW_W){1'b0}}, switches};
          end
        end
        DONE: begin
          state <= DRAIN;
        end
        DRAIN: begin
          if (!Ecall) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ecall_input_responder.sv
// Self-checking bench for ecall_input_responder with
// directed scenarios and randomized request loop.
module tb_ecall_input_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        Ecall;
  logic [31:0] a7;
  logic [7:0]  switches;
  logic        button;
  logic        claim;
  logic        busy;
  logic        EcallDone;
  logic        EcallWrite;
  logic [31:0] EcallResult;

  int          vectors = 0;
  int          miscompares = 0;
  int          done_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] res_at_done = '0;
  logic [31:0] exp_result = '0;

  ecall_input_responder #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Ecall      (Ecall),
    .a7         (a7),
    .switches   (switches),
    .button     (button),
    .claim      (claim),
    .busy       (busy),
    .EcallDone  (EcallDone),
    .EcallWrite (EcallWrite),
    .EcallResult(EcallResult)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (EcallDone) begin
      done_cnt++;
      res_at_done = EcallResult;
    end
    if (EcallWrite) wr_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] code,
                                        input logic [7:0] sw);
    if (code == 32'd5 && sw > 8'd127)
      return 32'(sw) - 32'd256;
    return 32'(sw);
  endfunction

  task automatic wait_pulse(input int d0, output int t);
    t = 0;
    while (done_cnt == d0 && t < 40) begin
      step(1);
      t++;
    end
  endtask

  task automatic run_req(input logic [31:0] code,
                         input logic [7:0] sw,
                         input bit bounce);
    int d0, w0, t;
    Ecall = 1'b1;
    a7 = code;
    switches = 8'($urandom);
    step(1);
    check("claim_req", 32'(claim), 32'd1);
    check("busy_req", 32'(busy), 32'd1);
    step(2);
    d0 = done_cnt;
    w0 = wr_cnt;
    if (bounce) begin
      repeat (2) begin
        button = 1'b1;
        switches = 8'($urandom);
        step(1);
        button = 1'b0;
        switches = 8'($urandom);
        step(1);
      end
    end
    switches = sw;
    button = 1'b1;
    wait_pulse(d0, t);
    step(10);
    check("claim_drain", 32'(claim), 32'd1);
    check("busy_drain", 32'(busy), 32'd1);
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("write_pulses", 32'(wr_cnt - w0), 32'd1);
    exp_result = model(code, sw);
    check("result_at_done", res_at_done, exp_result);
    check("result_held", EcallResult, exp_result);
    button = 1'b0;
    step(8);
    Ecall = 1'b0;
    step(2);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int d0, t;
    rst = 1'b0;
    Ecall = 1'b0;
    a7 = '0;
    switches = '0;
    button = 1'b0;
    step(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(EcallDone), 32'd0);
    check("rst_write", 32'(EcallWrite), 32'd0);
    check("rst_result", EcallResult, 32'd0);
    check("rst_claim", 32'(claim), 32'd0);
    rst = 1'b1;
    step(2);

    run_req(32'd5, 8'hF6, 1'b0);
    check("int_f6", EcallResult, 32'hFFFF_FFF6);
    run_req(32'd12, 8'hF6, 1'b0);
    check("uint_f6", EcallResult, 32'h0000_00F6);
    run_req(32'd5, 8'h3C, 1'b1);
    run_req(32'd5, 8'h81, 1'b1);

    // button held before the request arrives
    button = 1'b1;
    step(10);
    Ecall = 1'b1;
    a7 = 32'd12;
    switches = 8'h5A;
    d0 = done_cnt;
    step(20);
    check("held_no_pulse", 32'(done_cnt - d0), 32'd0);
    check("held_busy", 32'(busy), 32'd1);
    button = 1'b0;
    step(10);
    button = 1'b1;
    wait_pulse(d0, t);
    step(3);
    check("held_one_pulse", 32'(done_cnt - d0), 32'd1);
    exp_result = model(32'd12, 8'h5A);
    check("held_result", EcallResult, exp_result);
    button = 1'b0;
    step(8);
    Ecall = 1'b0;
    step(2);

    // foreign syscall is not claimed
    Ecall = 1'b1;
    a7 = 32'd1;
    switches = 8'h77;
    d0 = done_cnt;
    step(1);
    check("other_claim", 32'(claim), 32'd0);
    check("other_busy", 32'(busy), 32'd0);
    button = 1'b1;
    step(15);
    check("other_no_pulse", 32'(done_cnt - d0), 32'd0);
    check("other_result", EcallResult, exp_result);
    button = 1'b0;
    step(8);
    Ecall = 1'b0;
    step(2);

    // flush while waiting for the press
    Ecall = 1'b1;
    a7 = 32'd5;
    switches = 8'h11;
    d0 = done_cnt;
    step(5);
    Ecall = 1'b0;
    button = 1'b1;
    step(15);
    check("flush_no_pulse", 32'(done_cnt - d0), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_result", EcallResult, exp_result);
    button = 1'b0;
    step(8);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] code;
      code = ($urandom_range(0, 1) == 0) ? 32'd5 : 32'd12;
      run_req(code, 8'($urandom), 1'($urandom));
    end

    // reset in the middle of a wait
    Ecall = 1'b1;
    a7 = 32'd5;
    switches = 8'hAA;
    d0 = done_cnt;
    step(4);
    button = 1'b1;
    step(3);
    rst = 1'b0;
    step(1);
    exp_result = '0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(EcallDone), 32'd0);
    check("midrst_result", EcallResult, exp_result);
    Ecall = 1'b0;
    button = 1'b0;
    step(1);
    rst = 1'b1;
    step(10);
    check("midrst_no_pulse", 32'(done_cnt - d0), 32'd0);
    check("midrst_result2", EcallResult, exp_result);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
